// File: rtl/act_skew_feeder.sv
// -----------------------------------------------------------------------------
// act_skew_feeder
//
// Feeds activation vectors into a systolic PE array with a diagonal skew.
// A job loads COLS weight vectors (tagged load), then num_vecs activation
// vectors (tagged compute), then drains ROWS-1+COLS bubble cycles so the last
// slot has travelled through the whole array. Row r sees each slot r cycles
// after row 0, and row 0 sees it one cycle after the transfer.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle job start, honoured only while idle
//   num_vecs      activation vectors in the job, latched on accepted start
//   in_valid      upstream vector valid
//   in_data       upstream vector, lane r = [r*CDW +: CDW]
//   in_ready      feeder accepts in_data this cycle (LOAD / COMPUTE)
//   pe_data       skewed lanes to each PE row's data_in
//   pe_load_en    per-row load enable
//   pe_compute    per-row compute enable
//   stall_cycles  (optional) cycles with in_ready=1 and in_valid=0, saturating
//   busy          job in progress
//   done          one-cycle pulse on the final drain cycle
//
// Optional build macro: ACT_SKEW_FEEDER_STALL_CNT_EN adds stall_cycles[15:0].
// -----------------------------------------------------------------------------
module act_skew_feeder #(
  parameter int ROWS               = 4,
  parameter int COLS               = 4,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int VEC_COUNT_WIDTH    = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [VEC_COUNT_WIDTH-1:0]         num_vecs,
  input  logic                               in_valid,
  input  logic [ROWS*COMPUTE_DATA_WIDTH-1:0] in_data,
  output logic                               in_ready,
  output logic [ROWS*COMPUTE_DATA_WIDTH-1:0] pe_data,
  output logic [ROWS-1:0]                    pe_load_en,
  output logic [ROWS-1:0]                    pe_compute,
`ifdef ACT_SKEW_FEEDER_STALL_CNT_EN
  output logic [15:0]                        stall_cycles,
`endif
  output logic                               busy,
  output logic                               done
);

  localparam int CDW         = COMPUTE_DATA_WIDTH;
  localparam int VCW         = VEC_COUNT_WIDTH;
  localparam int LOAD_CNT_W  = $clog2(COLS + 1);
  localparam int DRAIN_LEN   = ROWS - 1 + COLS;
  localparam int DRAIN_CNT_W = $clog2(DRAIN_LEN + 1);

  localparam logic [LOAD_CNT_W-1:0]  LOAD_LAST  = LOAD_CNT_W'(COLS - 1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_LEN - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  logic [1:0]             state;
  logic [VCW-1:0]         num_vecs_q;
  logic [VCW-1:0]         vec_cnt;
  logic [LOAD_CNT_W-1:0]  load_cnt;
  logic [DRAIN_CNT_W-1:0] drain_cnt;

  logic                   xfer;
  logic                   load_last;
  logic                   vec_last;
  logic [VCW:0]           vec_next;

  logic [ROWS*CDW-1:0]    slot_data;
  logic                   slot_load;
  logic                   slot_comp;

  assign in_ready  = (state == ST_LOAD) || (state == ST_COMPUTE);
  assign xfer      = in_valid && in_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);
  assign load_last = (load_cnt == LOAD_LAST);

  // One extra bit so the terminal compare works for num_vecs = all-ones
  // without the counter ever wrapping.
  assign vec_next  = {1'b0, vec_cnt} + 1'b1;
  assign vec_last  = (vec_next == {1'b0, num_vecs_q});

  // Slot entering the skew pipeline this cycle; a cycle without a transfer
  // becomes an all-zero bubble so stale in_data never reaches the array.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    slot_data = '0;
    slot_load = 1'b0;
    slot_comp = 1'b0;
    if (xfer) begin
      slot_data = in_data;
      slot_load = (state == ST_LOAD);
      slot_comp = (state == ST_COMPUTE);
    end
  end

  // ---------------------------------------------------------------------------
  // Job sequencing
  // ---------------------------------------------------------------------------
  // NOTE: state elements use non-blocking assignments so every register in the
  // design samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      num_vecs_q <= '0;
      vec_cnt    <= '0;
      load_cnt   <= '0;
      drain_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LOAD;
            num_vecs_q <= num_vecs;
            vec_cnt    <= '0;
            load_cnt   <= '0;
            drain_cnt  <= '0;
          end
        end
        ST_LOAD: begin
          if (xfer) begin
            if (load_last) begin
              state <= (num_vecs_q == '0) ? ST_DRAIN : ST_COMPUTE;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (xfer) begin
            if (vec_last) begin
              state <= ST_DRAIN;
            end else begin
              vec_cnt <= vec_next[VCW-1:0];
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Skew pipeline: row r is a private delay line r+1 stages deep, so only the
  // lane each row actually uses is stored. It shifts every cycle; the array
  // never back-pressures the feeder.
  // ---------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [r:0][CDW-1:0] d_q;
    logic [r:0]          ld_q;
    logic [r:0]          cp_q;

    // NOTE: these delay lines are plain flops, not a memory, and they are
    // reset so the PE controls read 0 the moment rst_n drops.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d_q  <= '0;
        ld_q <= '0;
        cp_q <= '0;
      end else begin
        d_q[0]  <= slot_data[r*CDW +: CDW];
        ld_q[0] <= slot_load;
        cp_q[0] <= slot_comp;
        for (int k = 1; k <= r; k++) begin
          d_q[k]  <= d_q[k-1];
          ld_q[k] <= ld_q[k-1];
          cp_q[k] <= cp_q[k-1];
        end
      end
    end

    assign pe_data[r*CDW +: CDW] = d_q[r];
    assign pe_load_en[r]         = ld_q[r];
    assign pe_compute[r]         = cp_q[r];
  end

`ifdef ACT_SKEW_FEEDER_STALL_CNT_EN
  // ---------------------------------------------------------------------------
  // Upstream starvation counter: cycles the feeder could accept but nothing
  // was offered. Restarts with each job, holds at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((state == ST_IDLE) && start) begin
      stall_cycles <= '0;
    end else if (in_ready && !in_valid && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_act_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_act_skew_feeder
//
// Self-checking bench for act_skew_feeder at default parameters. A table of
// per-cycle records covers the reference job (num_vecs=2, in_valid held high);
// hand-written sequences cover num_vecs=0, a mid-COMPUTE stall, maximum
// num_vecs, and reset in the middle of a job. Define
// ACT_SKEW_FEEDER_STALL_CNT_EN to also check stall_cycles.
// -----------------------------------------------------------------------------
module tb_act_skew_feeder;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int CDW  = 4;
  localparam int VCW  = 8;
  localparam int DW   = ROWS * CDW;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [VCW-1:0]  num_vecs;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic            in_ready;
  logic [DW-1:0]   pe_data;
  logic [ROWS-1:0] pe_load_en;
  logic [ROWS-1:0] pe_compute;
  logic            busy;
  logic            done;
`ifdef ACT_SKEW_FEEDER_STALL_CNT_EN
  logic [15:0]     stall_cycles;
`endif

  act_skew_feeder #(
    .ROWS               (ROWS),
    .COLS               (COLS),
    .COMPUTE_DATA_WIDTH (CDW),
    .VEC_COUNT_WIDTH    (VCW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_vecs     (num_vecs),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .pe_data      (pe_data),
    .pe_load_en   (pe_load_en),
    .pe_compute   (pe_compute),
`ifdef ACT_SKEW_FEEDER_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " in_ready"},   32'(in_ready),   32'd0);
    check({tag, " pe_data"},    32'(pe_data),    32'd0);
    check({tag, " pe_load_en"}, 32'(pe_load_en), 32'd0);
    check({tag, " pe_compute"}, 32'(pe_compute), 32'd0);
    check({tag, " busy"},       32'(busy),       32'd0);
    check({tag, " done"},       32'(done),       32'd0);
  endtask

  // One job with in_valid held high except for sn cycles starting at cycle st
  // (which must fall inside COMPUTE). Cycle 0 carries start. The bench keeps
  // its own history of the slots it offered and expects row r at cycle c to
  // show the slot from cycle c-1-r.
  task automatic run_sched(input int nv, input int st, input int sn, input string tag);
    logic [DW-1:0] hd [512];
    logic          hl [512];
    logic          hc [512];
    int            ready_end;
    int            done_c;
    int            done_seen;
    logic [DW-1:0]   e_pd;
    logic [ROWS-1:0] e_ld;
    logic [ROWS-1:0] e_cp;
    logic            xf;
    ready_end = COLS + nv + sn;
    done_c    = ready_end + ROWS - 1 + COLS;
    done_seen = 0;
    for (int c = 0; c <= done_c + 1; c++) begin
      start    = (c == 0);
      num_vecs = VCW'(nv);
      in_valid = !((c >= st) && (c < st + sn));
      in_data  = DW'($urandom);
      xf       = in_valid && (c >= 1) && (c <= ready_end);
      hd[c]    = xf ? in_data : '0;
      hl[c]    = xf && (c <= COLS);
      hc[c]    = xf && (c > COLS);
      e_pd = '0;
      e_ld = '0;
      e_cp = '0;
      for (int r = 0; r < ROWS; r++) begin
        if (c - 1 - r >= 0) begin
          e_pd[r*CDW +: CDW] = hd[c-1-r][r*CDW +: CDW];
          e_ld[r]            = hl[c-1-r];
          e_cp[r]            = hc[c-1-r];
        end
      end
      @(negedge clk);
      check($sformatf("%s c%0d in_ready", tag, c), 32'(in_ready),
            32'((c >= 1) && (c <= ready_end)));
      check($sformatf("%s c%0d busy", tag, c), 32'(busy),
            32'((c >= 1) && (c <= done_c)));
      check($sformatf("%s c%0d done", tag, c), 32'(done), 32'(c == done_c));
      check($sformatf("%s c%0d pe_data", tag, c), 32'(pe_data), 32'(e_pd));
      check($sformatf("%s c%0d pe_load_en", tag, c), 32'(pe_load_en), 32'(e_ld));
      check($sformatf("%s c%0d pe_compute", tag, c), 32'(pe_compute), 32'(e_cp));
      check($sformatf("%s c%0d load&compute", tag, c), 32'(pe_load_en & pe_compute), 32'd0);
      if (done) done_seen++;
      step();
    end
    start = 1'b0;
    check({tag, " done pulses"}, 32'(done_seen), 32'd1);
  endtask

  typedef struct {
    logic            start;
    logic            vld;
    logic [DW-1:0]   data;
    logic            rdy;
    logic [DW-1:0]   pd;
    logic [ROWS-1:0] ld;
    logic [ROWS-1:0] cp;
    logic            bsy;
    logic            dn;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // Reference job, num_vecs=2. Loads DCBA 1F2E 5A6B 9C7D, computes 4321 8765.
    // Starts at rows 3 and 8 fall in LOAD / DRAIN and must be ignored.
    //           start vld data      rdy  pe_data  ld    cp    bsy   dn
    tbl[0]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 16'hDCBA, 1'b1, 16'h0000, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 16'h1F2E, 1'b1, 16'h000A, 4'h1, 4'h0, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 16'h5A6B, 1'b1, 16'h00BE, 4'h3, 4'h0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 16'h9C7D, 1'b1, 16'h0C2B, 4'h7, 4'h0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 16'h4321, 1'b1, 16'hDF6D, 4'hF, 4'h0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 16'h8765, 1'b1, 16'h1A71, 4'hE, 4'h1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h5C25, 4'hC, 4'h3, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 16'h9360, 4'h8, 4'h6, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h4700, 4'h0, 4'hC, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h8000, 4'h0, 4'h8, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    num_vecs = '0;
    in_valid = 1'b0;
    in_data  = '0;
    #2;
    check_all_zero("reset");
`ifdef ACT_SKEW_FEEDER_STALL_CNT_EN
    check("reset stall_cycles", 32'(stall_cycles), 32'd0);
`endif
    step();
    step();
    rst_n = 1'b1;
    step();

    // Table-driven reference job
    num_vecs = 8'd2;
    for (int i = 0; i < 15; i++) begin
      start    = tbl[i].start;
      in_valid = tbl[i].vld;
      in_data  = tbl[i].data;
      @(negedge clk);
      check($sformatf("tbl%0d in_ready", i),   32'(in_ready),   32'(tbl[i].rdy));
      check($sformatf("tbl%0d pe_data", i),    32'(pe_data),    32'(tbl[i].pd));
      check($sformatf("tbl%0d pe_load_en", i), 32'(pe_load_en), 32'(tbl[i].ld));
      check($sformatf("tbl%0d pe_compute", i), 32'(pe_compute), 32'(tbl[i].cp));
      check($sformatf("tbl%0d busy", i),       32'(busy),       32'(tbl[i].bsy));
      check($sformatf("tbl%0d done", i),       32'(done),       32'(tbl[i].dn));
      step();
    end
    start = 1'b0;

    // num_vecs = 0: four loads, straight to a 7-cycle drain
    run_sched(0, 0, 0, "nv0");

    // Three starved cycles in the middle of COMPUTE
    run_sched(3, 6, 3, "stall");
`ifdef ACT_SKEW_FEEDER_STALL_CNT_EN
    check("stall_cycles", 32'(stall_cycles), 32'd3);
`endif

    // Largest job the counter supports
    run_sched(255, 0, 0, "nvmax");

    // Reset mid-COMPUTE with a second start ignored during LOAD
    begin
      int done_seen;
      done_seen = 0;
      start    = 1'b1;
      num_vecs = 8'd5;
      in_valid = 1'b1;
      in_data  = 16'hA5A5;
      step();
      start = 1'b0;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (done) done_seen++;
        step();
      end
      check("abort in_ready before reset", 32'(in_ready), 32'd1);
      check("abort busy before reset", 32'(busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("abort async");
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        if (done) done_seen++;
        step();
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (done) done_seen++;
        check($sformatf("abort idle%0d busy", i), 32'(busy), 32'd0);
        check($sformatf("abort idle%0d in_ready", i), 32'(in_ready), 32'd0);
        step();
      end
      check("abort done pulses", 32'(done_seen), 32'd0);
`ifdef ACT_SKEW_FEEDER_STALL_CNT_EN
      check("abort stall_cycles", 32'(stall_cycles), 32'd0);
`endif
    end

    // Fresh job after the aborted one
    run_sched(2, 0, 0, "fresh");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/act_skew_feeder.md
ACT_SKEW_FEEDER -- requirements
Module: act_skew_feeder

Interface
REQ-001 Parameter ROWS, default 4: PE array rows fed, one lane per row.
REQ-002 Parameter COLS, default 4: PE array columns; sets the weight-load vector count and the drain length.
REQ-003 Parameter COMPUTE_DATA_WIDTH, default 4: lane data width, matching the PE data_in width.
REQ-004 Parameter VEC_COUNT_WIDTH, default 8: width of num_vecs and of the internal vector counter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle pulse that begins a job; sampled only in IDLE.
REQ-008 num_vecs  input  VEC_COUNT_WIDTH  activation vectors in the job; latched on accepted start.
REQ-009 in_valid  input  1  upstream vector valid.
REQ-010 in_data  input  ROWS*COMPUTE_DATA_WIDTH  upstream vector; lane r = bits [r*CDW +: CDW].
REQ-011 in_ready  output  1  feeder accepts in_data this cycle.
REQ-012 pe_data  output  ROWS*COMPUTE_DATA_WIDTH  skewed data to the PE rows' data_in.
REQ-013 pe_load_en  output  ROWS  per-row load_en to the PEs.
REQ-014 pe_compute  output  ROWS  per-row compute to the PEs.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at job completion.

Function
REQ-017 FSM states are IDLE, LOAD, COMPUTE and DRAIN.
REQ-018 IDLE->LOAD on start; num_vecs is latched and the vector counter is cleared.
REQ-019 start outside IDLE is ignored.
REQ-020 in_ready=1 only in LOAD and COMPUTE; a transfer occurs when in_valid and in_ready are both high.
REQ-021 LOAD accepts exactly COLS vectors, each tagged load; after the COLS-th transfer the FSM goes to COMPUTE, or to DRAIN if latched num_vecs=0.
REQ-022 COMPUTE accepts exactly latched num_vecs vectors, each tagged compute; after the last transfer the FSM goes to DRAIN.
REQ-023 Any cycle without a transfer injects a bubble slot: data 0, load 0, compute 0.
REQ-024 DRAIN lasts ROWS-1+COLS cycles of bubble slots; on its last cycle done=1, and the FSM is in IDLE the next cycle.
REQ-025 Skew: row r pe_data, pe_load_en and pe_compute equal the slot (data lane r, load, compute) formed r cycles earlier; row 0 is registered with 1-cycle latency from the transfer; row r has latency 1+r.
REQ-026 The skew pipeline shifts every cycle, independent of in_valid; no backpressure is taken from the array.
REQ-027 pe_load_en[r] and pe_compute[r] are never both 1.
REQ-028 No arithmetic is performed on data; lanes pass bit-exact.
REQ-029 The vector counter compares against latched num_vecs (count reaches num_vecs, terminal); num_vecs=2^VEC_COUNT_WIDTH-1 is supported without wrap.

Reset
REQ-030 rst_n low asynchronously clears the FSM to IDLE and clears all counters and skew registers; in_ready, pe_data, pe_load_en, pe_compute, busy and done all read 0.
REQ-031 Reset mid-job abandons the job with no done pulse; after rst_n rises the feeder waits for a new start.

Configuration
REQ-032 Macro ACT_SKEW_FEEDER_STALL_CNT_EN, when defined, adds output stall_cycles [15:0].
REQ-033 stall_cycles counts cycles with in_ready=1 and in_valid=0, saturates at 16'hFFFF, is cleared by accepted start, and reset to 0.
REQ-034 Without the macro, the port and the counter are absent; all other behaviour is identical.

Verification
REQ-035 Defaults, num_vecs=2, in_valid held 1 -> in_ready high 6 cycles; pe_load_en[0] high 4 cycles starting 1 cycle after start+1, pe_load_en[3] the same shifted by 3; then pe_compute[r] for 2 cycles; done exactly 7 cycles after the last transfer; busy falls with done+1.
REQ-036 Lane check: vector 0x4321 transferred in COMPUTE -> pe_data row0=1 at +1, row1=2 at +2, row2=3 at +3, row3=4 at +4.
REQ-037 in_valid low for 3 cycles mid-COMPUTE -> 3 bubble slots with compute 0 and data 0 per row, correctly skewed; stall_cycles=3 with the macro defined.
REQ-038 num_vecs=0 -> LOAD of 4 vectors, then DRAIN of 7 cycles; pe_compute never 1; one done pulse.
REQ-039 start pulsed again while busy, then rst_n low mid-COMPUTE -> second start ignored; all outputs 0 immediately on reset; no done; a fresh start after release runs normally.
